// File: rtl/name_column_sequencer.sv
// name_column_sequencer
// Walks a stored message one glyph column at a time toward the 8-LED column
// driver, inserting blank gap columns between characters. Glyph bitmaps come
// from an external combinational font ROM addressed by font_char/font_col.
// Optional build macro: SEQ_BITREV_EN -- glyph columns are bit-reversed
// (bit7 = top LED) for boards wired MSB-top; gap columns stay blank.
module name_column_sequencer #(
  parameter int MSG_DEPTH  = 16,
  parameter int GLYPH_COLS = 7,
  parameter int GAP_COLS   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [4:0]                   wr_char,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         start,
  input  logic                         loop_en,
  input  logic                         stop,
  output logic                         busy,
  output logic [4:0]                   font_char,
  output logic [2:0]                   font_col,
  input  logic [7:0]                   font_data,
  output logic                         col_valid,
  input  logic                         col_ready,
  output logic [7:0]                   col_data,
  output logic                         col_last,
  output logic                         done
);

  localparam int          AW         = $clog2(MSG_DEPTH);
  localparam logic [AW:0] DEPTH_L    = (AW+1)'(MSG_DEPTH);
  localparam logic [AW:0] LEN_ZERO   = (AW+1)'(0);
  localparam logic [AW:0] LEN_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ZERO = AW'(0);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [2:0]  GLYPH_LAST = 3'(GLYPH_COLS - 1);
  localparam logic [2:0]  GAP_LAST   = 3'(GAP_COLS - 1);
  localparam logic        HAS_GAP    = (GAP_COLS > 0);
  // A one-column glyph with no gap is already the last column of its character.
  localparam logic        FIRST_LAST = (GAP_COLS == 0) && (GLYPH_COLS == 1);
  localparam logic [4:0]  LAST_CODE  = 5'd26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GLYPH = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   char_idx_r;
  logic [AW:0]     len_r;
  logic            loop_r;
  logic            stop_r;
  logic [4:0]      msg_r [MSG_DEPTH];

  logic            xfer_s;
  logic            last_char_s;
  logic            finish_s;
  logic            boundary_s;
  logic [AW-1:0]   next_idx_s;
  logic [7:0]      glyph_s;

`ifdef SEQ_BITREV_EN
  function automatic logic [7:0] bit_reverse(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction
`endif

  // Character-boundary decode: transfer, end-of-character and next slot index.
  always_comb begin
    xfer_s      = col_valid & col_ready;
    last_char_s = ({1'b0, char_idx_r} == (len_r - LEN_ONE));
    finish_s    = stop_r | stop | (last_char_s & ~loop_r);
    boundary_s  = 1'b0;
    if (last_char_s) begin
      next_idx_s = IDX_ZERO;
    end else begin
      next_idx_s = char_idx_r + IDX_ONE;
    end
    case (state_r)
      GLYPH:   boundary_s = xfer_s & ~HAS_GAP & (font_col == GLYPH_LAST);
      GAP:     boundary_s = xfer_s & (font_col == GAP_LAST);
      default: boundary_s = 1'b0;
    endcase
  end

  // Column pattern: ROM bitmap during glyph columns, blank for gaps and reserved codes.
  always_comb begin
    glyph_s = 8'd0;
    if (font_char > LAST_CODE) begin
      glyph_s = 8'd0;
    end else begin
`ifdef SEQ_BITREV_EN
      glyph_s = bit_reverse(font_data);
`else
      glyph_s = font_data;
`endif
    end
    if (state_r == GLYPH) begin
      col_data = glyph_s;
    end else begin
      col_data = 8'd0;
    end
  end

  // Sequencer FSM, message store and registered handshake/font outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      char_idx_r <= IDX_ZERO;
      len_r      <= LEN_ZERO;
      loop_r     <= 1'b0;
      stop_r     <= 1'b0;
      busy       <= 1'b0;
      col_valid  <= 1'b0;
      col_last   <= 1'b0;
      done       <= 1'b0;
      font_char  <= 5'd0;
      font_col   <= 3'd0;
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg_r[i] <= 5'd0;
      end
    end else begin
      done <= 1'b0;
      // Message content is frozen while a playback is in progress.
      if (wr_en && (state_r == IDLE)) begin
        msg_r[wr_addr] <= wr_char;
      end
      // Stop is only remembered while playing; cleared again at termination.
      if (stop && (state_r != IDLE)) begin
        stop_r <= 1'b1;
      end
      if (state_r == IDLE) begin
        if (start) begin
          if (msg_len == LEN_ZERO) begin
            done <= 1'b1;
          end else begin
            len_r      <= (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
            loop_r     <= loop_en;
            char_idx_r <= IDX_ZERO;
            font_char  <= msg_r[0];
            font_col   <= 3'd0;
            state_r    <= GLYPH;
            busy       <= 1'b1;
            col_valid  <= 1'b1;
            col_last   <= FIRST_LAST;
          end
        end else begin
          state_r <= IDLE;
        end
      end else if (boundary_s) begin
        if (finish_s) begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          col_valid <= 1'b0;
          col_last  <= 1'b0;
          font_char <= 5'd0;
          font_col  <= 3'd0;
          stop_r    <= 1'b0;
          done      <= 1'b1;
        end else begin
          char_idx_r <= next_idx_s;
          font_char  <= msg_r[next_idx_s];
          font_col   <= 3'd0;
          state_r    <= GLYPH;
          col_last   <= FIRST_LAST;
        end
      end else if (xfer_s) begin
        if (state_r == GLYPH) begin
          if (font_col != GLYPH_LAST) begin
            font_col <= font_col + 3'd1;
            col_last <= ~HAS_GAP & ((font_col + 3'd1) == GLYPH_LAST);
          end else begin
            state_r  <= GAP;
            font_col <= 3'd0;
            col_last <= (GAP_LAST == 3'd0);
          end
        end else begin
          font_col <= font_col + 3'd1;
          col_last <= ((font_col + 3'd1) == GAP_LAST);
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_name_column_sequencer.sv
// Directed self-checking bench for name_column_sequencer (default parameters).
// A small font ROM model returns {col, char} for codes 1..31 and 0 for space,
// so every glyph column is distinct and reserved codes must be blanked.
module tb_name_column_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_char;
  logic [4:0] msg_len;
  logic       start;
  logic       loop_en;
  logic       stop;
  logic       busy;
  logic [4:0] font_char;
  logic [2:0] font_col;
  logic [7:0] font_data;
  logic       col_valid;
  logic       col_ready;
  logic [7:0] col_data;
  logic       col_last;
  logic       done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] exp_d[$];
  logic       exp_l[$];
  int stall_bad;
  int done_cnt;
  int done_lag;
  int timed_out;

  name_column_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .msg_len   (msg_len),
    .start     (start),
    .loop_en   (loop_en),
    .stop      (stop),
    .busy      (busy),
    .font_char (font_char),
    .font_col  (font_col),
    .font_data (font_data),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_data  (col_data),
    .col_last  (col_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Font ROM model.
  always_comb begin
    if (font_char == 5'd0) font_data = 8'h00;
    else font_data = {font_col, font_char};
  end

  function automatic logic [7:0] exp_col(input logic [4:0] c, input logic [2:0] k);
    logic [7:0] v;
    logic [7:0] r;
    if (c == 5'd0 || c > 5'd26) v = 8'h00;
    else v = {k, c};
    r = v;
`ifdef SEQ_BITREV_EN
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
`endif
    return r;
  endfunction

  task automatic build_exp(input logic [4:0] seq[$]);
    exp_d.delete();
    exp_l.delete();
    foreach (seq[i]) begin
      for (int k = 0; k < 7; k++) begin
        exp_d.push_back(exp_col(seq[i], 3'(k)));
        exp_l.push_back(1'b0);
      end
      exp_d.push_back(8'h00);
      exp_l.push_back(1'b1);
    end
  endtask

  task automatic write_char(input logic [3:0] a, input logic [4:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len, input logic lp);
    start = 1'b1; msg_len = len; loop_en = lp;
    @(negedge clk);
    start = 1'b0; loop_en = 1'b0;
  endtask

  // Drives col_ready per mode and records every transferred column until done.
  task automatic play(input int mode, input int max_cycles, input int stop_at, input bit poke);
    int         last_xfer;
    bit         have_hold;
    logic [7:0] hold_d;
    logic       hold_l;
    logic [4:0] hold_c;
    logic [2:0] hold_k;
    got_d.delete(); got_l.delete();
    stall_bad = 0; done_cnt = 0; done_lag = -1; timed_out = 1;
    last_xfer = -100; have_hold = 1'b0;
    hold_d = 8'h00; hold_l = 1'b0; hold_c = 5'd0; hold_k = 3'd0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_lag < 0) done_lag = cyc - last_xfer;
      end
      if (have_hold && (col_data !== hold_d || col_last !== hold_l ||
                        font_char !== hold_c || font_col !== hold_k || col_valid !== 1'b1))
        stall_bad++;
      if (busy === 1'b0 && done_cnt > 0) begin
        timed_out = 0;
        break;
      end
      case (mode)
        0:       col_ready = 1'b1;
        1:       col_ready = (cyc % 2 == 0);
        default: col_ready = ($urandom_range(0, 2) != 0);
      endcase
      stop    = (stop_at >= 0 && got_d.size() == stop_at);
      wr_en   = poke && (cyc == 3);
      wr_addr = 4'd1; wr_char = 5'd2;
      start   = poke && (cyc == 5);
      msg_len = 5'd1;
      if (col_valid === 1'b1 && col_ready) begin
        got_d.push_back(col_data);
        got_l.push_back(col_last);
        last_xfer = cyc;
        have_hold = 1'b0;
      end else if (col_valid === 1'b1) begin
        have_hold = 1'b1;
        hold_d = col_data; hold_l = col_last; hold_c = font_char; hold_k = font_col;
      end else begin
        have_hold = 1'b0;
      end
      @(negedge clk);
    end
    col_ready = 1'b0; stop = 1'b0; wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || col_valid !== 1'b0 || col_data !== 8'h00 || col_last !== 1'b0 ||
        done !== 1'b0 || font_char !== 5'd0 || font_col !== 3'd0) begin
      failures++;
      $display("FAIL reset_values got busy=%b valid=%b data=%h last=%b done=%b char=%0d col=%0d want all zero",
               busy, col_valid, col_data, col_last, done, font_char, font_col);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [4:0] seq[$];
    write_char(4'd0, 5'd13);
    write_char(4'd1, 5'd1);
    write_char(4'd2, 5'd20);
    // A stop in IDLE must not arm termination of the next playback.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    do_start(5'd3, 1'b0);
    checks++;
    if (col_valid !== 1'b1 || busy !== 1'b1 || font_char !== 5'd13 || font_col !== 3'd0) begin
      failures++;
      $display("FAIL basic_latency got valid=%b busy=%b char=%0d col=%0d want 1 1 13 0",
               col_valid, busy, font_char, font_col);
    end
    play(0, 200, -1, 1'b0);
    seq = {5'd13, 5'd1, 5'd20};
    build_exp(seq);
    checks++;
    if (got_d.size() !== exp_d.size() || timed_out !== 0) begin
      failures++;
      $display("FAIL basic_count got=%0d timeout=%0d want=%0d", got_d.size(), timed_out, exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL basic_col[%0d] got=%h/%b want=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (done_lag !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got lag=%0d busy=%b want lag=1 busy=0", done_lag, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || col_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width got done=%b valid=%b want 0 0", done, col_valid);
    end
  endtask

  task automatic test_stall();
    logic [4:0] seq[$];
    seq = {5'd13, 5'd1, 5'd20};
    build_exp(seq);
    for (int m = 1; m <= 2; m++) begin
      do_start(5'd3, 1'b0);
      // Second run also pokes a write and a start while busy; both must be dropped.
      play(m, 400, -1, (m == 2));
      checks++;
      if (got_d.size() !== exp_d.size() || timed_out !== 0) begin
        failures++;
        $display("FAIL stall%0d_count got=%0d timeout=%0d want=%0d", m, got_d.size(), timed_out, exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
          failures++;
          $display("FAIL stall%0d_col[%0d] got=%h/%b want=%h/%b", m, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
        end
      end
      checks++;
      if (stall_bad !== 0 || done_lag !== 1) begin
        failures++;
        $display("FAIL stall%0d_hold got unstable=%0d lag=%0d want 0 and 1", m, stall_bad, done_lag);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_loop_stop();
    logic [4:0] seq[$];
    int         stop_pt;
    write_char(4'd0, 5'd1);
    write_char(4'd1, 5'd0);
    for (int r = 0; r < 2; r++) begin
      // Run 0: stop mid-glyph of the third character. Run 1: stop on a boundary transfer.
      stop_pt = (r == 0) ? 19 : 15;
      if (r == 0) seq = {5'd1, 5'd0, 5'd1};
      else seq = {5'd1, 5'd0};
      build_exp(seq);
      do_start(5'd2, 1'b1);
      play(0, 200, stop_pt, 1'b0);
      checks++;
      if (got_d.size() !== exp_d.size() || timed_out !== 0) begin
        failures++;
        $display("FAIL loop%0d_count got=%0d timeout=%0d want=%0d", r, got_d.size(), timed_out, exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
          failures++;
          $display("FAIL loop%0d_col[%0d] got=%h/%b want=%h/%b", r, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
        end
      end
      checks++;
      if (done_lag !== 1) begin
        failures++;
        $display("FAIL loop%0d_done got lag=%0d want 1", r, done_lag);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_len_edge();
    logic [4:0] seq[$];
    logic [4:0] c;
    do_start(5'd0, 1'b0);
    checks++;
    if (done !== 1'b1 || col_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL len0_pulse got done=%b valid=%b busy=%b want 1 0 0", done, col_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || col_valid !== 1'b0) begin
      failures++;
      $display("FAIL len0_after got done=%b valid=%b want 0 0", done, col_valid);
    end
    seq.delete();
    for (int i = 0; i < 16; i++) begin
      // Slots 14 and 15 carry reserved codes, which must play as blank glyphs.
      c = (i < 14) ? 5'(i + 1) : ((i == 14) ? 5'd28 : 5'd31);
      write_char(4'(i), c);
      seq.push_back(c);
    end
    build_exp(seq);
    do_start(5'd20, 1'b0);
    play(0, 400, -1, 1'b0);
    checks++;
    if (got_d.size() !== exp_d.size() || timed_out !== 0) begin
      failures++;
      $display("FAIL len20_count got=%0d timeout=%0d want=%0d", got_d.size(), timed_out, exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL len20_col[%0d] got=%h/%b want=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [4:0] seq[$];
    int         n;
    write_char(4'd0, 5'd13);
    write_char(4'd1, 5'd1);
    write_char(4'd2, 5'd20);
    do_start(5'd3, 1'b0);
    col_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 9; c++) begin
      if (col_valid === 1'b1) n++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (col_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || col_data !== 8'h00 ||
        col_last !== 1'b0 || font_char !== 5'd0 || font_col !== 3'd0) begin
      failures++;
      $display("FAIL midreset_values got valid=%b busy=%b done=%b data=%h last=%b char=%0d col=%0d want all zero",
               col_valid, busy, done, col_data, col_last, font_char, font_col);
    end
    reset = 1'b0; col_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_nodone got done=%b busy=%b want 0 0", done, busy);
    end
    for (int r = 0; r < 2; r++) begin
      // Run 0 plays the cleared slot 0 (space); run 1 replays a rewritten message.
      if (r == 0) begin
        seq = {5'd0};
        do_start(5'd1, 1'b0);
      end else begin
        seq = {5'd13, 5'd1, 5'd20};
        write_char(4'd0, 5'd13);
        write_char(4'd1, 5'd1);
        write_char(4'd2, 5'd20);
        do_start(5'd3, 1'b0);
      end
      build_exp(seq);
      play(0, 200, -1, 1'b0);
      checks++;
      if (got_d.size() !== exp_d.size() || timed_out !== 0) begin
        failures++;
        $display("FAIL replay%0d_count got=%0d timeout=%0d want=%0d", r, got_d.size(), timed_out, exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
          failures++;
          $display("FAIL replay%0d_col[%0d] got=%h/%b want=%h/%b", r, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bitrev();
    logic [7:0] want0;
`ifdef SEQ_BITREV_EN
    want0 = 8'b1000_0000;
`else
    want0 = 8'b0000_0001;
`endif
    write_char(4'd0, 5'd1);
    do_start(5'd1, 1'b0);
    checks++;
    if (font_data !== 8'b0000_0001 || col_data !== want0) begin
      failures++;
      $display("FAIL bitrev_first got rom=%b data=%b want rom=00000001 data=%b", font_data, col_data, want0);
    end
    play(0, 100, -1, 1'b0);
    checks++;
    if (got_d.size() !== 8 || got_d[7] !== 8'h00 || got_l[7] !== 1'b1) begin
      failures++;
      $display("FAIL bitrev_gap got count=%0d want count=8 with blank last gap column", got_d.size());
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_char = 5'd0; msg_len = 5'd0;
    start = 1'b0; loop_en = 1'b0; stop = 1'b0; col_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_loop_stop();
    test_len_edge();
    test_reset_mid();
    test_bitrev();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
